// File: rtl/on_chip_ram_pkg.sv
// on_chip_ram_pkg: shared sizes and bus payload types for the on-chip RAM.
package on_chip_ram_pkg;

  localparam int unsigned ADDR_W    = 11;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned NUM_BYTES = DATA_W / 8;
  localparam int unsigned DEPTH     = 2048;

  typedef logic [ADDR_W-1:0]    addr_t;
  typedef logic [DATA_W-1:0]    word_t;
  typedef logic [NUM_BYTES-1:0] byteena_t;

  // Built-in preload images, selected by image name; unlisted words are zero.
  function automatic word_t init_word(input string name, input int unsigned idx);
    word_t w;
    w = '0;
    if (name == "bios.hex") begin
      if (idx == 0) w = 64'hDEADBEEFCAFEF00D;
    end
    return w;
  endfunction

endpackage : on_chip_ram_pkg

// File: rtl/on_chip_ram_if.sv
// on_chip_ram_if: single-port RAM access bus (request fields plus registered read data).
interface on_chip_ram_if
  import on_chip_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_W,
  parameter int unsigned DATA_WIDTH = DATA_W
);

  logic                    clken;
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] byteena;
  logic [DATA_WIDTH-1:0]   data;
  logic                    wren;
  logic [DATA_WIDTH-1:0]   q;

  modport master (
    output clken,
    output address,
    output byteena,
    output data,
    output wren,
    input  q
  );

  modport slave (
    input  clken,
    input  address,
    input  byteena,
    input  data,
    input  wren,
    output q
  );

endinterface : on_chip_ram_if

// File: rtl/on_chip_ram_lane.sv
// on_chip_ram_lane: one byte lane of the RAM, a 2**ADDR_WIDTH x 8 single-port
// block with its own write enable and registered read-old-data output.
// Optional preload: ONCHIP_RAM_INIT_EN (lane LANE of each INIT_FILE word).
module on_chip_ram_lane
  import on_chip_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_W
`ifdef ONCHIP_RAM_INIT_EN
  , parameter int unsigned DATA_WIDTH = DATA_W,
  parameter int unsigned LANE = 0,
  parameter string INIT_FILE = "bios.hex"
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clken,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [7:0]            data,
  output logic [7:0]            q
);

  localparam int unsigned LANE_DEPTH = 1 << ADDR_WIDTH;

  typedef logic [7:0] lane_mem_t [LANE_DEPTH];

`ifdef ONCHIP_RAM_INIT_EN
  // Preload image: this lane's byte of each image word.
  function automatic lane_mem_t lane_image();
    lane_mem_t             img;
    logic [DATA_WIDTH-1:0] w;
    for (int unsigned j = 0; j < LANE_DEPTH; j++) begin
      w      = DATA_WIDTH'(init_word(INIT_FILE, j));
      img[j] = w[8*LANE +: 8];
    end
    return img;
  endfunction
`else
  // No preload: all-zero contents.
  function automatic lane_mem_t lane_image();
    lane_mem_t img;
    for (int unsigned j = 0; j < LANE_DEPTH; j++) img[j] = '0;
    return img;
  endfunction
`endif

  lane_mem_t mem = lane_image();

  // Write port; reset suppresses any write on that edge.
  always_ff @(posedge clock) begin
    if (!reset && we) begin
      mem[address] <= data;
    end
  end

  // Read port: samples the pre-write contents, holds while clken is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (clken) begin
      q <= mem[address];
    end
  end

endmodule : on_chip_ram_lane

// File: rtl/on_chip_ram.sv
// on_chip_ram: single-port synchronous RAM, 2048 x 64 with byte enables and
// clock enable, built from one independent block RAM per byte lane.
// Optional preload from INIT_FILE: define ONCHIP_RAM_INIT_EN.
module on_chip_ram
  import on_chip_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_W,
  parameter int unsigned DATA_WIDTH = DATA_W
`ifdef ONCHIP_RAM_INIT_EN
  , parameter string INIT_FILE = "bios.hex"
`endif
) (
  input  logic          clock,
  input  logic          reset,
  on_chip_ram_if.slave  bus
);

  localparam int unsigned NUM_LANES = DATA_WIDTH / 8;

  logic [NUM_LANES-1:0]      lane_we;
  logic [NUM_LANES-1:0][7:0] lane_q;

  // Per-lane write enable; a low clken masks any X on wren/byteena.
  assign lane_we = {NUM_LANES{bus.clken & bus.wren}} & bus.byteena;
  assign bus.q   = lane_q;

  for (genvar i = 0; i < int'(NUM_LANES); i++) begin : g_lane
    on_chip_ram_lane #(
      .ADDR_WIDTH (ADDR_WIDTH)
`ifdef ONCHIP_RAM_INIT_EN
      , .DATA_WIDTH (DATA_WIDTH),
      .LANE       (i),
      .INIT_FILE  (INIT_FILE)
`endif
    ) u_lane (
      .clock   (clock),
      .reset   (reset),
      .clken   (bus.clken),
      .we      (lane_we[i]),
      .address (bus.address),
      .data    (bus.data[8*i +: 8]),
      .q       (lane_q[i])
    );
  end

endmodule : on_chip_ram

// File: tb/tb_on_chip_ram.sv
// tb_on_chip_ram: directed and randomized checks against a word-array model.
module tb_on_chip_ram;
  import on_chip_ram_pkg::*;

  logic clock = 1'b0;
  logic reset;

  on_chip_ram_if bus ();

  on_chip_ram dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int    checks = 0;
  int    errors = 0;
  word_t ref_mem [DEPTH];
  word_t exp_q;

  task automatic check_eq(input string tag, input word_t got, input word_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, update the model, and advance past the edge.
  task automatic apply(input logic rst, input logic ce, input logic we,
                       input addr_t a, input byteena_t be, input word_t d);
    reset       = rst;
    bus.clken   = ce;
    bus.wren    = we;
    bus.address = a;
    bus.byteena = be;
    bus.data    = d;
    if (rst) begin
      exp_q = '0;
    end else if (ce) begin
      exp_q = ref_mem[a];
      if (we) begin
        for (int i = 0; i < int'(NUM_BYTES); i++)
          if (be[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    addr_t    pool [16];
    addr_t    a;
    byteena_t be;
    word_t    d;
    logic     rst, ce, we;

    for (int j = 0; j < int'(DEPTH); j++) ref_mem[j] = '0;
`ifdef ONCHIP_RAM_INIT_EN
    ref_mem[0] = 64'hDEADBEEFCAFEF00D;
`endif
    exp_q = '0;

    // Reset with a write request present
    apply(1'b1, 1'b1, 1'b1, 11'h000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("reset_q", bus.q, 64'h0);

    // Power-up contents at both ends of the address range
    apply(1'b0, 1'b1, 1'b0, 11'h7FF, 8'h00, 64'h0);
    check_eq("top_addr_init", bus.q, 64'h0);
    apply(1'b0, 1'b1, 1'b0, 11'h000, 8'h00, 64'h0);
`ifdef ONCHIP_RAM_INIT_EN
    check_eq("addr0_init", bus.q, 64'hDEADBEEFCAFEF00D);
`else
    check_eq("addr0_init", bus.q, 64'h0);
`endif

    // Full-word write then read
    apply(1'b0, 1'b1, 1'b1, 11'h400, 8'hFF, 64'h0123456789ABCDEF);
    check_eq("full_wr_old", bus.q, 64'h0);
    apply(1'b0, 1'b1, 1'b0, 11'h400, 8'h00, 64'h0);
    check_eq("full_rd", bus.q, 64'h0123456789ABCDEF);

    // Byte-masked write touches lanes 0 and 7 only
    apply(1'b0, 1'b1, 1'b1, 11'h400, 8'h81, 64'hFFFF_FFFF_FFFF_FFFF);
    apply(1'b0, 1'b1, 1'b0, 11'h400, 8'h00, 64'h0);
    check_eq("byte_mask", bus.q, 64'hFF23456789ABCDFF);

    // Clock enable low freezes q and blocks writes
    apply(1'b0, 1'b1, 1'b1, 11'h010, 8'hFF, 64'h1111);
    apply(1'b0, 1'b1, 1'b0, 11'h010, 8'h00, 64'h0);
    check_eq("ce_setup", bus.q, 64'h1111);
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b0, 1'b1, 11'h400, (k == 1) ? 8'hxx : 8'hFF, 64'h0);
      check_eq($sformatf("ce_hold%0d", k), bus.q, 64'h1111);
    end
    apply(1'b0, 1'b1, 1'b0, 11'h400, 8'h00, 64'h0);
    check_eq("ce_no_write", bus.q, 64'hFF23456789ABCDFF);

    // Read-during-write at the last address returns old data
    apply(1'b0, 1'b1, 1'b1, 11'h7FF, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA);
    apply(1'b0, 1'b1, 1'b1, 11'h7FF, 8'hFF, 64'h5555_5555_5555_5555);
    check_eq("rdw_old", bus.q, 64'hAAAA_AAAA_AAAA_AAAA);
    apply(1'b0, 1'b1, 1'b0, 11'h7FF, 8'h00, 64'h0);
    check_eq("rdw_new", bus.q, 64'h5555_5555_5555_5555);

    // Reset clears q without writing memory
    apply(1'b0, 1'b1, 1'b1, 11'h400, 8'hFF, 64'h0123456789ABCDEF);
    apply(1'b0, 1'b1, 1'b0, 11'h400, 8'h00, 64'h0);
    check_eq("rst_pre", bus.q, 64'h0123456789ABCDEF);
    apply(1'b1, 1'b1, 1'b1, 11'h400, 8'hFF, 64'h0);
    check_eq("rst_q", bus.q, 64'h0);
    apply(1'b0, 1'b1, 1'b0, 11'h400, 8'h00, 64'h0);
    check_eq("rst_mem_kept", bus.q, 64'h0123456789ABCDEF);

    // Randomized traffic over a small pool, each address fully written first
    pool[0] = 11'h000;
    pool[1] = 11'h7FF;
    for (int k = 2; k < 16; k++) pool[k] = addr_t'($urandom_range(1, 2046));
    for (int k = 0; k < 16; k++)
      apply(1'b0, 1'b1, 1'b1, pool[k], 8'hFF, {$urandom, $urandom});
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 31) == 0);
      ce  = ($urandom_range(0, 3) != 0);
      we  = $urandom_range(0, 1) == 1;
      a   = pool[$urandom_range(0, 15)];
      be  = byteena_t'($urandom);
      d   = {$urandom, $urandom};
      apply(rst, ce, we, a, be, d);
      check_eq($sformatf("rand%0d", n), bus.q, exp_q);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_on_chip_ram
